// File: rtl/serializer_pkg.sv
// serializer_pkg: FSM state type and default word width shared with the deserializer
package serializer_pkg;
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
   localparam int WORD_WIDTH = 8;
endpackage

// File: rtl/serializer.sv
// serializer: parallel word to MSB-first serial bit stream with per-bit strobe and ready backpressure
module serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic             clock_100KHZ,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   input  logic             ready_in,
   output logic             data_ack,
   output logic             data_out,
   output logic             write_out,
   output logic             status_out,
   output logic [7:0]       words_sent
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ack_q, ack_d;
   logic             dout_q, dout_d;
   logic             wr_q, wr_d;
   logic             stat_q, stat_d;
   logic [7:0]       words_q, words_d;
   // next state: capture in IDLE, shift one bit per ready cycle, retire the word once WIDTH bits have gone
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      dout_d  = 1'b0;
      wr_d    = 1'b0;
      stat_d  = stat_q;
      words_d = words_q;
      case (state_q)
         IDLE: if (data_valid) begin
            shift_d = data_in;
            cnt_d   = '0;
            ack_d   = 1'b1;
            stat_d  = 1'b1;
            state_d = SEND;
         end
         SEND: if (cnt_q == CW'(WIDTH)) begin
            stat_d  = 1'b0;
            words_d = words_q + 8'd1;
            state_d = DONE;
         end else if (ready_in) begin
            dout_d  = shift_q[WIDTH-1];
            wr_d    = 1'b1;
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered outputs, cleared immediately by reset
   always_ff @(posedge clock_100KHZ or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         dout_q  <= 1'b0;
         wr_q    <= 1'b0;
         stat_q  <= 1'b0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         dout_q  <= dout_d;
         wr_q    <= wr_d;
         stat_q  <= stat_d;
         words_q <= words_d;
      end
   end
   assign data_ack   = ack_q;
   assign data_out   = dout_q;
   assign write_out  = wr_q;
   assign status_out = stat_q;
   assign words_sent = words_q;
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: queue-driven stimulus, bit-stream receiver model and word counter model
module tb_serializer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = '0;
   logic       data_valid = 1'b0;
   logic       ready_in = 1'b1;
   logic       data_ack, data_out, write_out, status_out;
   logic [7:0] words_sent;
   int checks = 0, errors = 0;
   logic [7:0] txq[$], expw[$];
   bit   rxbits[$];
   int   ack_cyc[$], str_cyc[$];
   int   acks, cyc, mode, pause_left, exp_words;
   serializer #(.WIDTH(8)) dut (
      .clock_100KHZ(clk), .reset(rst_n), .data_in(data_in), .data_valid(data_valid),
      .ready_in(ready_in), .data_ack(data_ack), .data_out(data_out), .write_out(write_out),
      .status_out(status_out), .words_sent(words_sent)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive_queue();
      data_valid = txq.size() > 0;
      data_in    = txq.size() > 0 ? txq[0] : 8'h00;
   endtask
   task automatic cycle();
      if (mode == 3 && rxbits.size() % 8 == 2 && pause_left > 0) begin
         ready_in = 1'b0;
         pause_left--;
      end else if (mode == 1) ready_in = 1'($urandom_range(0, 1));
      else if (mode == 2) ready_in = ~ready_in;
      else ready_in = 1'b1;
      drive_queue();
      @(posedge clk);
      #1;
      cyc++;
      if (data_ack) begin
         acks++;
         ack_cyc.push_back(cyc);
         if (txq.size() > 0) void'(txq.pop_front());
      end
      if (write_out) begin
         rxbits.push_back(data_out);
         str_cyc.push_back(cyc);
      end else chk("dout_zero_when_no_strobe", data_out, 0);
   endtask
   task automatic start(input int m);
      mode = m;
      pause_left = 3;
      cyc = 0;
      acks = 0;
      rxbits.delete();
      ack_cyc.delete();
      str_cyc.delete();
   endtask
   task automatic run(input string tag, input int m, input int budget);
      int n;
      logic [7:0] b;
      start(m);
      n = 0;
      do begin
         cycle();
         n++;
      end while ((txq.size() > 0 || status_out) && n < budget);
      chk({tag, "_budget"}, n < budget, 1);
      cycle();
      cycle();
      chk({tag, "_acks"}, acks, expw.size());
      chk({tag, "_nbits"}, rxbits.size(), 8 * expw.size());
      for (int i = 0; i < expw.size(); i++) begin
         b = '0;
         for (int k = 0; k < 8; k++)
            if (i * 8 + k < rxbits.size()) b = {b[6:0], 1'(rxbits[i * 8 + k])};
         chk({tag, "_byte"}, b, expw[i]);
      end
      exp_words = (exp_words + expw.size()) % 256;
      chk({tag, "_words_sent"}, words_sent, exp_words);
      chk({tag, "_status_idle"}, status_out, 0);
   endtask
   task automatic load(input logic [7:0] w);
      txq.push_back(w);
      expw.push_back(w);
   endtask
   initial begin
      int n;
      exp_words = 0;
      #1;
      chk("rst_outputs", {data_ack, data_out, write_out, status_out}, 0);
      chk("rst_words", words_sent, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      // single word, ready always high
      expw.delete(); load(8'hA5);
      run("a5", 0, 40);
      chk("a5_ack_count", ack_cyc.size(), 1);
      if (str_cyc.size() == 8) begin
         chk("a5_first_latency", str_cyc[0] - ack_cyc[0], 1);
         chk("a5_consecutive", str_cyc[7] - str_cyc[0], 7);
      end
      // three-cycle backpressure after the second bit
      expw.delete(); load(8'h3C);
      run("3c", 3, 40);
      if (str_cyc.size() == 8) chk("3c_gap", str_cyc[2] - str_cyc[1], 4);
      // back-to-back words with data_valid held
      expw.delete(); load(8'hFF); load(8'h01);
      run("b2b", 0, 60);
      if (str_cyc.size() == 16) begin
         chk("b2b_idle_gap", str_cyc[8] - str_cyc[7] >= 2, 1);
         chk("b2b_burst2", str_cyc[15] - str_cyc[8], 7);
      end
      // ready toggling every cycle
      expw.delete(); load(8'($urandom));
      run("toggle", 2, 60);
      // reset in the middle of a word
      expw.delete(); txq.push_back(8'hF0);
      start(0);
      n = 0;
      while (rxbits.size() < 4 && n < 30) begin
         cycle();
         n++;
      end
      chk("mid_reach4", rxbits.size(), 4);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_outputs", {data_ack, data_out, write_out, status_out}, 0);
      chk("mid_rst_words", words_sent, 0);
      exp_words = 0;
      txq.delete();
      load(8'h81);
      drive_queue();
      @(posedge clk);
      #1;
      chk("mid_held_ack", data_ack, 0);
      chk("mid_held_words", words_sent, 0);
      #2 rst_n = 1'b1;
      run("after_rst", 0, 40);
      if (ack_cyc.size() > 0) chk("after_rst_first_sample", ack_cyc[0], 1);
      // random loopback under random backpressure; 1 + 255 words wraps the counter
      expw.delete();
      for (int i = 0; i < 255; i++) load(8'($urandom));
      run("wrap", 1, 20000);
      chk("wrap_zero", words_sent, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter: WIDTH, 8, number of bits per word, for both data_in and the shift register.
REQ-002 clock_100KHZ  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 data_in  input  WIDTH  parallel word presented by the upstream queue.
REQ-005 data_valid  input  1  upstream queue holds a word on data_in.
REQ-006 ready_in  input  1  downstream deserializer is accepting bits (its status_out).
REQ-007 data_ack  output  1  one-cycle pulse: data_in captured; queue pops.
REQ-008 data_out  output  1  serial bit, MSB first.
REQ-009 write_out  output  1  bit strobe: data_out is valid this cycle.
REQ-010 status_out  output  1  high while a word is loaded or being shifted.
REQ-011 words_sent  output  8  count of completed words, wraps 255 -> 0.

Function
REQ-012 FSM states: IDLE, SEND, DONE; all outputs SHALL be registered.
REQ-013 IDLE with data_valid=1 at edge N SHALL capture data_in into the shift register, clear the bit counter and enter SEND; data_ack=1 and status_out=1 SHALL be visible in cycle N+1.
REQ-014 data_ack SHALL be high for exactly one cycle per captured word and never outside the IDLE->SEND transition.
REQ-015 data_in and data_valid SHALL be ignored outside IDLE.
REQ-016 SEND, per edge with ready_in=1: data_out <= shift MSB, write_out <= 1, shift left by one, bit counter +1.
REQ-017 SEND, per edge with ready_in=0: write_out <= 0, data_out <= 0; shift register and counter hold (pause, no bit lost or repeated).
REQ-018 data_out SHALL be 0 whenever write_out=0.
REQ-019 After the WIDTH-th strobed bit SHALL enter DONE: write_out <= 0, status_out <= 0, words_sent +1 (modulo 256).
REQ-020 DONE SHALL return to IDLE unconditionally after one cycle, so consecutive words have at least one idle cycle between last and first strobe.
REQ-021 Minimum latency: data_valid sampled at edge N with ready_in held 1 -> first write_out in cycle N+2, last in cycle N+1+WIDTH.
REQ-022 Bit counter width SHALL be $clog2(WIDTH)+1 so that the value WIDTH is representable without wrap.
REQ-023 ready_in toggling every cycle SHALL yield exactly WIDTH strobes per word, in order.

Reset
REQ-024 reset=0 SHALL immediately force: state IDLE, data_ack=0, data_out=0, write_out=0, status_out=0, words_sent=0, shift register and counter 0.
REQ-025 Reset mid-word SHALL abort the word without completing it or incrementing words_sent; after release the block SHALL wait in IDLE for data_valid.
REQ-026 First data_valid sample SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-027 Shared package SHALL hold the state enum (IDLE, SEND, DONE) and the default word-width constant (8), common with the deserializer.
REQ-028 Single module; no sub-module required (shift register and counters are inline).

Verification
REQ-029 Send 8'hA5, ready_in=1 throughout -> data_ack 1 cycle, write_out high 8 consecutive cycles, data_out 1,0,1,0,0,1,0,1, words_sent=1.
REQ-030 Send 8'h3C, ready_in low for 3 cycles after bit 2 -> write_out gap of 3 cycles, bits 0,0,1,1,1,1,0,0 intact, words_sent=1.
REQ-031 Back-to-back queue 8'hFF then 8'h01, data_valid held 1 -> two data_ack pulses, one idle cycle between bursts, 16 correct bits, words_sent=2.
REQ-032 reset=0 after 4 bits of 8'hF0 -> all outputs 0 immediately, words_sent stays 0; next word 8'h81 sends cleanly.
REQ-033 Send 256 words -> words_sent wraps to 0.
REQ-034 Loopback into the deserializer with random bytes and random ready_in -> received bytes equal sent bytes, in order.
